bank_refill_ctrl: RTL and testbench

Bank-granular refill controller that owns the four cached-bank tag registers feeding the pseudo-LRU victim selector and acts on the victim index it returns. For each access request of one or two bank addresses, it checks the four tags. Missing banks are refilled from DRAM into the chosen slot with a burst read, and the block then grants the access with the slot number of each requested bank. It sits between the access front-end, the pLRU block and the DRAM read port.

---
 rtl/bank_refill_ctrl_pkg.sv | 20 ++
 rtl/bank_tag_store.sv | 72 +++++++
 rtl/bank_refill_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bank_refill_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_refill_ctrl_pkg.sv
// Shared definitions for the bank refill controller: default geometry,
// slot index type and the controller state encoding.
package bank_refill_ctrl_pkg;

  localparam int BANK_W = 4;
  localparam int BEATS  = 16;
  localparam int DATA_W = 64;
  localparam int NSLOT  = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_AR,
    ST_RDATA,
    ST_GRANT
  } state_t;

endpackage

// File: rtl/bank_tag_store.sv
// Four-slot tag store for the refill controller.
// Holds a tag and a valid bit per slot, reports hits for the two looked-up
// banks and the lowest-index invalid slot.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bank_0, bank_1      : banks to look up
//   clr, clr_slot       : invalidate a slot (start of its refill)
//   wr, wr_slot, wr_tag : write a tag and mark the slot valid
//   tags                : raw tag registers, reported regardless of valid
//   hit_*, hit_slot_*   : per-bank hit and the slot holding it
//   free_any, free_slot : an invalid slot exists / lowest such slot
module bank_tag_store #(
  parameter int BANK_W = bank_refill_ctrl_pkg::BANK_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BANK_W-1:0]      bank_0,
  input  logic [BANK_W-1:0]      bank_1,
  input  logic                   clr,
  input  logic [1:0]             clr_slot,
  input  logic                   wr,
  input  logic [1:0]             wr_slot,
  input  logic [BANK_W-1:0]      wr_tag,
  output logic [3:0][BANK_W-1:0] tags,
  output logic                   hit_0,
  output logic [1:0]             hit_slot_0,
  output logic                   hit_1,
  output logic [1:0]             hit_slot_1,
  output logic                   free_any,
  output logic [1:0]             free_slot
);
  import bank_refill_ctrl_pkg::*;

  logic [NSLOT-1:0] valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      tags  <= '0;
    end else begin
      if (clr) valid[clr_slot] <= 1'b0;
      if (wr) begin
        valid[wr_slot] <= 1'b1;
        tags[wr_slot]  <= wr_tag;
      end
    end
  end

  // Scanning from the top slot down lets the lowest index win.
  always_comb begin
    hit_0      = 1'b0;
    hit_slot_0 = '0;
    hit_1      = 1'b0;
    hit_slot_1 = '0;
    free_any   = 1'b0;
    free_slot  = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == bank_0) begin
        hit_0      = 1'b1;
        hit_slot_0 = slot_t'(i);
      end
      if (valid[i] && tags[i] == bank_1) begin
        hit_1      = 1'b1;
        hit_slot_1 = slot_t'(i);
      end
      if (!valid[i]) begin
        free_any  = 1'b1;
        free_slot = slot_t'(i);
      end
    end
  end

endmodule

// File: rtl/bank_refill_ctrl.sv
// Bank-granular refill controller.
// Accepts one or two bank addresses, refills missing banks from DRAM into
// a free or pLRU-chosen slot, then grants the access with each bank's slot.
//   req_*                  : access request handshake and bank addresses
//   victim_idx             : pLRU victim slot, sampled in LOOKUP only
//   base_bank_0..3         : slot tags, fed to the pLRU block
//   lru_upd_0/1            : access pulses, coincident with grant_valid
//   dram_ar_* / dram_r_*   : refill address and data channels
//   sram_*                 : slot data write port
//   grant_valid/grant_slot : access complete, slot of each requested bank
module bank_refill_ctrl #(
  parameter int  BANK_W = bank_refill_ctrl_pkg::BANK_W,
  parameter int  BEATS  = bank_refill_ctrl_pkg::BEATS,
  parameter int  DATA_W = bank_refill_ctrl_pkg::DATA_W,
  localparam int CNT_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_use_1,
  input  logic [BANK_W-1:0] req_bank_0,
  input  logic [BANK_W-1:0] req_bank_1,
  input  logic [1:0]        victim_idx,
  output logic [BANK_W-1:0] base_bank_0,
  output logic [BANK_W-1:0] base_bank_1,
  output logic [BANK_W-1:0] base_bank_2,
  output logic [BANK_W-1:0] base_bank_3,
  output logic              lru_upd_0,
  output logic              lru_upd_1,
  output logic              dram_ar_valid,
  input  logic              dram_ar_ready,
  output logic [BANK_W-1:0] dram_ar_bank,
  input  logic              dram_r_valid,
  input  logic [DATA_W-1:0] dram_r_data,
  input  logic              dram_r_last,
  output logic              sram_we,
  output logic [1:0]        sram_slot,
  output logic [CNT_W-1:0]  sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              grant_valid,
  output logic [1:0]        grant_slot_0,
  output logic [1:0]        grant_slot_1
);
  import bank_refill_ctrl_pkg::*;

  state_t                 state, state_nxt;
  logic [BANK_W-1:0]      bank_0_r, bank_1_r;
  logic                   use_1_r;
  slot_t                  fill_slot_r, fill_slot_nxt;
  logic [BANK_W-1:0]      fill_bank_r, fill_bank_nxt;
  logic [CNT_W-1:0]       beat_cnt;

  logic [3:0][BANK_W-1:0] tags;
  logic                   hit_0, hit_1, free_any;
  slot_t                  hit_slot_0, hit_slot_1, free_slot;
  logic                   tag_clr, tag_wr, beat;
  logic                   miss_0, miss_1, other_hit;
  slot_t                  other_slot, victim_alt, pick_slot;

  bank_tag_store #(.BANK_W(BANK_W)) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank_0     (bank_0_r),
    .bank_1     (bank_1_r),
    .clr        (tag_clr),
    .clr_slot   (fill_slot_r),
    .wr         (tag_wr),
    .wr_slot    (fill_slot_r),
    .wr_tag     (fill_bank_r),
    .tags       (tags),
    .hit_0      (hit_0),
    .hit_slot_0 (hit_slot_0),
    .hit_1      (hit_1),
    .hit_slot_1 (hit_slot_1),
    .free_any   (free_any),
    .free_slot  (free_slot)
  );

  // With use_1 clear, bank_1 is treated as a hit and never protects a slot.
  assign miss_0     = !hit_0;
  assign miss_1     = use_1_r && !hit_1;
  assign other_hit  = miss_0 ? (use_1_r && hit_1) : hit_0;
  assign other_slot = miss_0 ? hit_slot_1 : hit_slot_0;
  // Never evict the slot holding the other bank of this same request.
  assign victim_alt = (other_hit && other_slot == victim_idx) ? slot_t'(victim_idx + 2'd1)
                                                              : victim_idx;
  assign pick_slot  = free_any ? free_slot : victim_alt;

  assign beat = (state == ST_RDATA) && dram_r_valid;

  always_comb begin
    state_nxt     = state;
    fill_slot_nxt = fill_slot_r;
    fill_bank_nxt = fill_bank_r;
    req_ready     = 1'b0;
    dram_ar_valid = 1'b0;
    grant_valid   = 1'b0;
    lru_upd_0     = 1'b0;
    lru_upd_1     = 1'b0;
    tag_clr       = 1'b0;
    tag_wr        = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!miss_0 && !miss_1) begin
          state_nxt = ST_GRANT;
        end else begin
          fill_slot_nxt = pick_slot;
          fill_bank_nxt = miss_0 ? bank_0_r : bank_1_r;
          state_nxt     = ST_AR;
        end
      end
      ST_AR: begin
        dram_ar_valid = 1'b1;
        if (dram_ar_ready) begin
          tag_clr   = 1'b1;
          state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
        // A short burst still tags the slot; the missing beats are not flagged.
        if (beat && dram_r_last) begin
          tag_wr    = 1'b1;
          state_nxt = ST_LOOKUP;
        end
      end
      ST_GRANT: begin
        grant_valid = 1'b1;
        lru_upd_0   = 1'b1;
        lru_upd_1   = use_1_r;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bank_0_r    <= '0;
      bank_1_r    <= '0;
      use_1_r     <= 1'b0;
      fill_slot_r <= '0;
      fill_bank_r <= '0;
      beat_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      fill_slot_r <= fill_slot_nxt;
      fill_bank_r <= fill_bank_nxt;
      if (req_valid && req_ready) begin
        bank_0_r <= req_bank_0;
        bank_1_r <= req_bank_1;
        use_1_r  <= req_use_1;
      end
      if (beat) begin
        beat_cnt <= (dram_r_last || beat_cnt == CNT_W'(BEATS - 1)) ? '0
                                                                    : beat_cnt + CNT_W'(1);
      end
    end
  end

  assign base_bank_0  = tags[0];
  assign base_bank_1  = tags[1];
  assign base_bank_2  = tags[2];
  assign base_bank_3  = tags[3];
  assign dram_ar_bank = fill_bank_r;
  assign sram_we      = beat;
  assign sram_slot    = fill_slot_r;
  assign sram_addr    = beat_cnt;
  assign sram_wdata   = beat ? dram_r_data : '0;
  assign grant_slot_0 = grant_valid ? hit_slot_0 : '0;
  assign grant_slot_1 = grant_valid ? (use_1_r ? hit_slot_1 : hit_slot_0) : '0;

endmodule

// File: tb/tb_bank_refill_ctrl.sv
// Self-checking bench for bank_refill_ctrl: a table of access requests with
// hand-derived refill and grant expectations, a scoreboard of expected SRAM
// writes and grants, plus reset and AR-stall corner sequences.
`timescale 1ns/1ps
module tb_bank_refill_ctrl;
  localparam int BANK_W = 4;
  localparam int BEATS  = 16;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_ready, req_use_1 = 1'b0;
  logic [BANK_W-1:0] req_bank_0 = '0, req_bank_1 = '0;
  logic [1:0]        victim_idx = '0;
  logic [BANK_W-1:0] base_bank_0, base_bank_1, base_bank_2, base_bank_3;
  logic              lru_upd_0, lru_upd_1;
  logic              dram_ar_valid, dram_ar_ready = 1'b0;
  logic [BANK_W-1:0] dram_ar_bank;
  logic              dram_r_valid = 1'b0, dram_r_last = 1'b0;
  logic [DATA_W-1:0] dram_r_data = '0;
  logic              sram_we;
  logic [1:0]        sram_slot;
  logic [3:0]        sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              grant_valid;
  logic [1:0]        grant_slot_0, grant_slot_1;

  bank_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_use_1(req_use_1),
    .req_bank_0(req_bank_0), .req_bank_1(req_bank_1), .victim_idx(victim_idx),
    .base_bank_0(base_bank_0), .base_bank_1(base_bank_1),
    .base_bank_2(base_bank_2), .base_bank_3(base_bank_3),
    .lru_upd_0(lru_upd_0), .lru_upd_1(lru_upd_1),
    .dram_ar_valid(dram_ar_valid), .dram_ar_ready(dram_ar_ready), .dram_ar_bank(dram_ar_bank),
    .dram_r_valid(dram_r_valid), .dram_r_data(dram_r_data), .dram_r_last(dram_r_last),
    .sram_we(sram_we), .sram_slot(sram_slot), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .grant_valid(grant_valid), .grant_slot_0(grant_slot_0), .grant_slot_1(grant_slot_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  slot;
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  typedef struct packed {
    logic [1:0] g0;
    logic [1:0] g1;
    logic       upd1;
  } gr_t;

  typedef struct {
    bit         use_1;
    logic [3:0] b0, b1;
    logic [1:0] victim;
    int         nref;
    logic [3:0] ar0;
    logic [1:0] fs0;
    logic [3:0] ar1;
    logic [1:0] fs1;
    logic [1:0] g0, g1;
    int         stall;
  } vec_t;

  vec_t vecs[8];
  wr_t  wr_q[$];
  gr_t  gr_q[$];
  wr_t  mon_w;
  gr_t  mon_g;
  int   n_checks = 0, n_pass = 0;
  bit   grant_seen = 1'b0;
  int   grant_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit u, int b0, int b1, int vic, int nref, int ar0, int fs0,
                              int ar1, int fs1, int g0, int g1, int stall);
    vec_t v;
    v.use_1 = u;        v.b0 = 4'(b0);     v.b1 = 4'(b1);   v.victim = 2'(vic);
    v.nref = nref;      v.ar0 = 4'(ar0);   v.fs0 = 2'(fs0);
    v.ar1 = 4'(ar1);    v.fs1 = 2'(fs1);   v.g0 = 2'(g0);   v.g1 = 2'(g1);
    v.stall = stall;
    return v;
  endfunction

  // Scoreboard monitor: pops expected SRAM writes and grants as the DUT emits them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_we) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL sram_unexpected: write slot %0d addr %0d data %0h, none expected",
                   sram_slot, sram_addr, sram_wdata);
        end else begin
          mon_w = wr_q.pop_front();
          chk("sram_slot", sram_slot, mon_w.slot);
          chk("sram_addr", sram_addr, mon_w.addr);
          chk("sram_wdata", sram_wdata, mon_w.data);
        end
      end
      if (grant_valid) begin
        grant_seen = 1'b1;
        grant_cyc  = cyc;
        if (gr_q.size() == 0) begin
          n_checks++;
          $display("FAIL grant_unexpected: slots %0d/%0d, none expected", grant_slot_0, grant_slot_1);
        end else begin
          mon_g = gr_q.pop_front();
          chk("grant_slot_0", grant_slot_0, mon_g.g0);
          chk("grant_slot_1", grant_slot_1, mon_g.g1);
          chk("lru_upd_0", lru_upd_0, 1);
          chk("lru_upd_1", lru_upd_1, mon_g.upd1);
        end
      end else if (lru_upd_0 || lru_upd_1) begin
        chk("lru_without_grant", {lru_upd_0, lru_upd_1}, 0);
      end
    end
  end

  // DRAM responder for one refill; abort_beat >= 0 asserts reset at that beat.
  task automatic serve_refill(input logic [3:0] bank, input logic [1:0] slot, input int stall,
                              input int abort_beat, output int ar_cyc, output int last_cyc);
    int  n;
    wr_t w;
    n = 0;
    last_cyc = 0;
    while (!dram_ar_valid && n < 20) begin
      tick();
      n++;
    end
    ar_cyc = cyc;
    chk("ar_valid", dram_ar_valid, 1);
    chk("ar_bank", dram_ar_bank, bank);
    for (int s = 0; s < stall; s++) begin
      // Stray beats while the address is pending must not reach the SRAM.
      dram_r_valid = 1'b1;
      dram_r_last  = (s == 0);
      dram_r_data  = 64'hdead_beef_0000_0000 | 64'(s);
      tick();
      chk("ar_hold_valid", dram_ar_valid, 1);
      chk("ar_hold_bank", dram_ar_bank, bank);
    end
    dram_r_valid  = 1'b0;
    dram_r_last   = 1'b0;
    dram_ar_ready = 1'b1;
    tick();
    dram_ar_ready = 1'b0;
    chk("ar_dropped", dram_ar_valid, 0);
    for (int i = 0; i < BEATS; i++) begin
      dram_r_data = {$urandom(), $urandom()};
      if (i == abort_beat) begin
        dram_r_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort_sram_we", sram_we, 0);
        chk("abort_ar_valid", dram_ar_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_grant", grant_valid, 0);
        return;
      end
      if (i == 5) begin
        dram_r_valid = 1'b0;
        dram_r_last  = 1'b0;
        tick();
      end
      dram_r_valid = 1'b1;
      dram_r_last  = (i == BEATS - 1);
      w.slot = slot;
      w.addr = 4'(i);
      w.data = dram_r_data;
      wr_q.push_back(w);
      last_cyc = cyc;
      tick();
    end
    dram_r_valid = 1'b0;
    dram_r_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  c0, arc, lc, n;
    gr_t g;
    bit  ar_late;
    victim_idx = v.victim;
    grant_seen = 1'b0;
    g.g0 = v.g0;
    g.g1 = v.g1;
    g.upd1 = v.use_1;
    gr_q.push_back(g);
    req_valid  = 1'b1;
    req_use_1  = v.use_1;
    req_bank_0 = v.b0;
    req_bank_1 = v.b1;
    c0 = cyc;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
    lc = 0;
    if (v.nref >= 1) begin
      serve_refill(v.ar0, v.fs0, v.stall, -1, arc, lc);
      chk("ar_latency", arc, c0 + 2);
    end
    if (v.nref >= 2) serve_refill(v.ar1, v.fs1, 0, -1, arc, lc);
    n = 0;
    ar_late = 1'b0;
    while (!grant_seen && n < 40) begin
      ar_late |= dram_ar_valid;
      tick();
      n++;
    end
    chk("grant_seen", grant_seen, 1);
    chk("extra_ar", ar_late, 0);
    chk("grant_latency", grant_cyc, (v.nref == 0) ? c0 + 2 : lc + 2);
    chk("sram_q_drained", wr_q.size(), 0);
    chk("grant_q_drained", gr_q.size(), 0);
    tick();
  endtask

  initial begin
    int arc, lc;
    //               u  b0 b1 vic nref ar0 fs0 ar1 fs1 g0 g1 stall
    vecs[0] = mk(1,  3, 5,  0,  2,   3,  0,  5,  1,  0, 1, 0);
    vecs[1] = mk(1,  7, 9,  0,  2,   7,  2,  9,  3,  2, 3, 0);
    vecs[2] = mk(1,  7, 9,  0,  0,   0,  0,  0,  0,  2, 3, 0);
    vecs[3] = mk(1,  3, 11, 0,  1,  11,  1,  0,  0,  0, 1, 5);
    vecs[4] = mk(0,  6, 3,  2,  1,   6,  2,  0,  0,  2, 2, 0);
    vecs[5] = mk(1, 12, 12, 3,  1,  12,  3,  0,  0,  3, 3, 0);
    vecs[6] = mk(1,  9, 6,  2,  1,   9,  3,  0,  0,  3, 2, 0);
    vecs[7] = mk(1,  5, 13, 1,  2,   5,  1, 13,  2,  1, 2, 0);

    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_ar_valid", dram_ar_valid, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_lru", {lru_upd_0, lru_upd_1}, 0);
    chk("rst_tags", {base_bank_0, base_bank_1, base_bank_2, base_bank_3}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);
    chk("tags_final", {base_bank_0, base_bank_1, base_bank_2, base_bank_3}, 16'h35d9);

    // Reset in the middle of a refill of bank 4 into slot 0.
    victim_idx = 2'd0;
    req_valid  = 1'b1;
    req_use_1  = 1'b0;
    req_bank_0 = 4'd4;
    req_bank_1 = 4'd0;
    tick();
    req_valid = 1'b0;
    serve_refill(4'd4, 2'd0, 0, 8, arc, lc);
    chk("abort_tag_slot0", base_bank_0, 0);
    chk("abort_sram_q", wr_q.size(), 0);
    tick();
    dram_r_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    run_vec(mk(0, 4, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
    chk("tag_after_restart", base_bank_0, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
